// File: rtl/riscv_trace_pkg.sv
// Shared types for the riscv execution-trace capture stage.
// Macro RISCV_TRACE_TIMESTAMP_EN adds a timestamp field to each record.
package riscv_trace_pkg;

  // Record field widths; the top-level width parameters must match these.
  localparam int unsigned REC_DATA_W = 32;
  localparam int unsigned REC_ADDR_W = 9;
  localparam int unsigned REC_TS_W   = 16;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Bit positions inside trace_rec_t.flags
  typedef enum logic [1:0] {
    TR_REG_WR = 2'd0,
    TR_MEM_WR = 2'd1,
    TR_MEM_RD = 2'd2
  } trace_flag_e;

  typedef struct packed {
    logic [2:0]            flags;
    logic [4:0]            reg_num;
    logic [REC_DATA_W-1:0] reg_data;
    logic [REC_ADDR_W-1:0] addr;
    logic [REC_DATA_W-1:0] mem_data;
`ifdef RISCV_TRACE_TIMESTAMP_EN
    logic [REC_TS_W-1:0]   ts;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_sync_fifo.sv
// Generic show-ahead synchronous FIFO. The head element is presented on rdata
// whenever the FIFO is non-empty; rdata reads as zero when empty.
module trace_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter type T = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Pop only a present head; a push into a full FIFO needs a same-cycle pop.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = empty ? '0 : mem[rptr];
    fill    = count;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/riscv_trace_fifo.sv
// Execution-trace capture: packs core writeback / memory side-band activity
// into records, buffers them, and counts records dropped on back-pressure.
// Macro RISCV_TRACE_TIMESTAMP_EN enables the per-record timestamp.
import riscv_trace_pkg::*;

module riscv_trace_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [2:0]             trace_flags,
  output logic [4:0]             trace_reg,
  output logic [DATA_W-1:0]      trace_reg_data,
  output logic [ADDR_W-1:0]      trace_addr,
  output logic [DATA_W-1:0]      trace_mem_data,
  output logic [TS_W-1:0]        trace_ts,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  trace_rec_t rec;
  trace_rec_t head;
  logic       reg_wr;
  logic       push_req;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;

`ifdef RISCV_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running timestamp, wraps from all-ones to zero.
  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end
`endif

  // Qualify this cycle's core activity and pack it into a record.
  always_comb begin
    reg_wr                 = reg_write_sig && (reg_num != 5'd0);
    push_req               = reg_wr || wr || rd;
    rec                    = '0;
    rec.flags[TR_REG_WR]   = reg_wr;
    rec.flags[TR_MEM_WR]   = wr;
    rec.flags[TR_MEM_RD]   = rd;
    rec.reg_num            = reg_wr ? reg_num : 5'd0;
    rec.reg_data           = reg_wr ? REC_DATA_W'(reg_data) : '0;
    rec.addr               = REC_ADDR_W'(addr);
    // Store data wins when both strobes are high.
    rec.mem_data           = wr ? REC_DATA_W'(wr_data) :
                             rd ? REC_DATA_W'(rd_data) : '0;
`ifdef RISCV_TRACE_TIMESTAMP_EN
    rec.ts                 = REC_TS_W'(ts_q);
`endif
  end

  trace_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata (rec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  // Unpack the head record onto the trace port.
  always_comb begin
    trace_valid    = !empty;
    pop            = trace_valid && trace_ready;
    drop           = push_req && full && !pop;
    trace_flags    = head.flags;
    trace_reg      = head.reg_num;
    trace_reg_data = DATA_W'(head.reg_data);
    trace_addr     = ADDR_W'(head.addr);
    trace_mem_data = DATA_W'(head.mem_data);
`ifdef RISCV_TRACE_TIMESTAMP_EN
    trace_ts       = TS_W'(head.ts);
`else
    trace_ts       = '0;
`endif
  end

  // Sticky overflow and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: doc/riscv_trace_fifo.md
# riscv_trace_fifo

Execution-trace capture stage directly downstream of the `riscv` core. It consumes the core's architectural side-band outputs each cycle: register writeback (`reg_num`/`reg_data`/`reg_write_sig`) and data-memory access (`wr`/`rd`/`addr`/`wr_data`/`rd_data`). Each active cycle is packed into one timestamped trace record and buffered in a FIFO. Records drain through a valid/ready port to a testbench monitor, UART dumper, or debug bus.

## Interface
Parameters:
- `DATA_W`, 32, register and memory data width.
- `ADDR_W`, 9, data-memory address width.
- `DEPTH`, 16, FIFO entries; must be a power of two, ≥ 2.
- `TS_W`, 16, timestamp width.

Ports:
- `clk`  in  1  core clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `reg_write_sig`  in  1  core register-file write strobe.
- `reg_num`  in  5  destination register index.
- `reg_data`  in  DATA_W  writeback value.
- `wr`  in  1  data-memory write strobe.
- `rd`  in  1  data-memory read strobe.
- `addr`  in  ADDR_W  data-memory address.
- `wr_data`  in  DATA_W  store data.
- `rd_data`  in  DATA_W  load data.
- `trace_valid`  out  1  head record is present.
- `trace_ready`  in  1  consumer accepts the head record.
- `trace_flags`  out  3  {mem_rd, mem_wr, reg_wr} of the head record.
- `trace_reg`  out  5  head record register index.
- `trace_reg_data`  out  DATA_W  head record writeback value.
- `trace_addr`  out  ADDR_W  head record memory address.
- `trace_mem_data`  out  DATA_W  head record memory data.
- `trace_ts`  out  TS_W  head record timestamp.
- `fill`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky flag: at least one record was dropped.
- `drop_cnt`  out  16  dropped-record count, saturating.

## Operation
- Capture qualifiers, evaluated each cycle:
  - `reg_wr = reg_write_sig && reg_num != 0`. Writes to x0 are ignored.
  - `mem_wr = wr`
  - `mem_rd = rd`
- A push request exists when any qualifier is 1. The record contains:
  - the qualifier flags;
  - `reg_num` and `reg_data`, both zeroed when `reg_wr` = 0;
  - `addr`;
  - `mem_data` = `wr_data` if `wr`, otherwise `rd_data` if `rd`, otherwise 0. If `wr` and `rd` are both high, both flags are set and `wr_data` is stored;
  - the current timestamp value.
- FIFO is show-ahead: the head record is always on the `trace_*` outputs while `trace_valid` = 1. Output fields hold 0 when the FIFO is empty.
- Pop occurs when `trace_valid && trace_ready`. Asserting `trace_ready` while `trace_valid` = 0 has no effect.
- Full, push without pop: record dropped, `overflow` set, `drop_cnt` incremented, saturating at 16'hFFFF.
- Full, push with pop in the same cycle: the push is accepted and `fill` is unchanged.
- Empty, push with pop in the same cycle: no pop occurs, since `trace_valid` was 0. The push is accepted.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Occupancy is tracked by `fill`, not by pointer comparison.
- The core is never stalled. Back-pressure results only in dropped records.

## Timing
- Reset values: `trace_valid` = 0, `fill` = 0, `overflow` = 0, `drop_cnt` = 0, timestamp = 0, all `trace_*` data fields = 0.
- Reset asserted mid-operation discards all buffered records on the next edge. A push request during the reset cycle is ignored.
- Latency: an event sampled at edge N appears on the outputs with `trace_valid` = 1 after edge N (visible in cycle N+1) if the FIFO was empty.
- `trace_*` fields update on the edge after a pop.
- `fill` and `overflow` update on the same edge as the push or pop.
- Timestamp is a free-running `TS_W`-bit counter. It increments every non-reset cycle and wraps from all-ones to 0. Each record stores the value in its capture cycle.
- Throughput: one record per cycle in and one record per cycle out.

## Configuration
- Macro: `RISCV_TRACE_TIMESTAMP_EN`.
- Defined: the timestamp counter is built and the timestamp is stored per record.
- Undefined: no counter and no storage for the timestamp field. `trace_ts` is tied to 0. All other behaviour is identical.

## Structure
- Package `riscv_trace_pkg`:
  - `trace_flag_e` bit positions: `TR_REG_WR` = 0, `TR_MEM_WR` = 1, `TR_MEM_RD` = 2;
  - packed struct `trace_rec_t` with fields flags, reg, reg_data, addr, mem_data, ts;
  - localparam `DROP_MAX` = 16'hFFFF.
- Sub-module `trace_sync_fifo`: generic show-ahead synchronous FIFO parameterised by `DEPTH` and element type. It provides `push`/`pop`/`full`/`empty`/`fill`.
- The top level handles capture packing, the timestamp counter, and drop accounting.

## Test plan
- Reset, then drive `reg_write_sig`=1, `reg_num`=5, `reg_data`=32'h1234 for one cycle with `trace_ready`=0. Next cycle: `trace_valid`=1, `trace_flags`=3'b001, `trace_reg`=5, `fill`=1.
- Drive `reg_write_sig`=1 with `reg_num`=0 and no memory strobe: no push; `trace_valid` and `fill` stay 0.
- Drive `wr`=1, `addr`=9'h040, `wr_data`=32'hDEAD_BEEF in the same cycle as register write x7: a single record with `trace_flags`=3'b011 and `trace_mem_data`=32'hDEAD_BEEF.
- With `trace_ready`=0, push DEPTH+3 = 19 events: `fill`=16, `overflow`=1, `drop_cnt`=3. Then hold `trace_ready`=1: the 16 records drain in original order and `trace_valid` drops after the 16th.
- With the FIFO full, apply a push and `trace_ready`=1 in the same cycle: `fill` stays 16, `drop_cnt` is unchanged, and the new record drains last.
- With the macro defined: after 65536+2 cycles, a captured record shows `trace_ts`=1 (wrap). With the macro undefined: `trace_ts`=0 for every record.
